// File: rtl/bp_pkg.sv
// Shared constants and sizing helpers for the dynamic branch predictor.
// No logic, no latency, no flow control.
// Counter encoding: 0/1 predict not-taken, 2/3 predict taken.
package bp_pkg;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    function automatic int entries_of(input int idx_w);
        return 1 << idx_w;
    endfunction

    // Tag covers everything above the index and the two ignored byte bits.
    function automatic int tag_w_of(input int xlen, input int idx_w);
        return xlen - idx_w - 2;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and resolve-side update bundle for the branch predictor.
// Lookup and resolution signals are combinational; update is captured on the clock edge.
// No backpressure: the core qualifies updates with upd_valid.
interface branch_predictor_if #(
    parameter int XLEN   = 32,
    parameter int STAT_W = 32
);
    logic [XLEN-1:0]   lk_pc;
    logic              lk_hit;
    logic              lk_taken;
    logic [XLEN-1:0]   lk_target;

    logic              upd_valid;
    logic [XLEN-1:0]   upd_pc;
    logic              upd_is_branch;
    logic              upd_is_jump;
    logic              upd_taken;
    logic [XLEN-1:0]   upd_target;
    logic              upd_pred_taken;
    logic [XLEN-1:0]   upd_pred_target;

    logic              mispredict;
    logic [XLEN-1:0]   redirect_pc;
    logic [STAT_W-1:0] stat_mispred;

    modport master (
        output lk_pc,
        input  lk_hit, lk_taken, lk_target,
        output upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
        output upd_target, upd_pred_taken, upd_pred_target,
        input  mispredict, redirect_pc, stat_mispred
    );

    modport slave (
        input  lk_pc,
        output lk_hit, lk_taken, lk_target,
        input  upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
        input  upd_target, upd_pred_taken, upd_pred_target,
        output mispredict, redirect_pc, stat_mispred
    );

endinterface

// File: rtl/bp_sat_ctr.sv
// Next-state function of one 2-bit saturating direction counter.
// Purely combinational, zero latency.
// No flow control; the caller decides whether the result is written.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    input  logic       alloc,
    input  logic       is_jump,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (is_jump) begin
            ctr_next = CTR_ST;
        end else if (alloc) begin
            // A fresh entry starts weak so one contrary outcome flips it.
            ctr_next = taken ? CTR_WT : CTR_WNT;
        end else if (taken) begin
            ctr_next = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end else begin
            ctr_next = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters; fetch lookup plus resolve-time update.
// Lookup and mispredict/redirect are zero latency; table writes are visible the next cycle.
// No backpressure: one lookup and at most one update are accepted every cycle.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int         XLEN     = 32,
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CTR_INIT = CTR_WNT,
    parameter int         STAT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bp
);

    localparam int ENTRIES = entries_of(IDX_W);
    localparam int TAG_W   = tag_w_of(XLEN, IDX_W);

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] jmp_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [STAT_W-1:0]  stat_q;

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;
    logic               lk_taken;
    logic [XLEN-1:0]    lk_target;

    logic [IDX_W-1:0]   upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;
    logic               upd_alloc;
    logic               actual_taken;
    logic               mispredict;
    logic [XLEN-1:0]    redirect_pc;
    logic [1:0]         ctr_next;

    // Byte-offset bits never take part in indexing or tagging.
    logic               unused_pc_lsb;
    assign unused_pc_lsb = ^{bp.lk_pc[1:0], bp.upd_pc[1:0]};

    assign lk_idx  = bp.lk_pc[IDX_W+1:2];
    assign lk_tag  = bp.lk_pc[XLEN-1:IDX_W+2];
    assign upd_idx = bp.upd_pc[IDX_W+1:2];
    assign upd_tag = bp.upd_pc[XLEN-1:IDX_W+2];

    always_comb begin
        lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken  = lk_hit && (jmp_q[lk_idx] || ctr_q[lk_idx][1]);
        lk_target = lk_taken ? tgt_q[lk_idx] : bp.lk_pc + XLEN'(4);
    end

    always_comb begin
        actual_taken = bp.upd_is_jump || (bp.upd_is_branch && bp.upd_taken);
        // A correct direction with a stale target still needs a redirect.
        mispredict  = bp.upd_valid &&
                      ((bp.upd_pred_taken != actual_taken) ||
                       (actual_taken && (bp.upd_pred_target != bp.upd_target)));
        redirect_pc = actual_taken ? bp.upd_target : bp.upd_pc + XLEN'(4);
    end

    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_alloc = !upd_hit;

    bp_sat_ctr u_sat_ctr (
        .ctr      (ctr_q[upd_idx]),
        .taken    (bp.upd_taken),
        .alloc    (upd_alloc),
        .is_jump  (bp.upd_is_jump),
        .ctr_next (ctr_next)
    );

    // Tag, target and jump flag are only observed behind a valid bit, so they skip reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (bp.upd_valid) begin
            if (bp.upd_is_jump || bp.upd_is_branch) begin
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= upd_tag;
                tgt_q[upd_idx]   <= bp.upd_target;
                jmp_q[upd_idx]   <= bp.upd_is_jump;
                ctr_q[upd_idx]   <= ctr_next;
            end else if (upd_hit) begin
                // A non-control instruction matched: the entry is an alias or stale.
                valid_q[upd_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_q <= '0;
        end else if (mispredict && (stat_q != {STAT_W{1'b1}})) begin
            stat_q <= stat_q + STAT_W'(1);
        end
    end

    assign bp.lk_hit       = lk_hit;
    assign bp.lk_taken     = lk_taken;
    assign bp.lk_target    = lk_target;
    assign bp.mispredict   = mispredict;
    assign bp.redirect_pc  = redirect_pc;
    assign bp.stat_mispred = stat_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline.
- Replaces the current static predict-not-taken scheme, which resolves in MEM and flushes three stages.
- Combines a direct-mapped BTB with per-entry 2-bit saturating counters.
- IF queries it each cycle for a next-PC guess; the resolving stage updates it and gets back a mispredict flag plus a redirect PC.

Parameters:
- XLEN, 32, address/data width.
- IDX_W, 4, index bits; ENTRIES = 2**IDX_W.
- CTR_INIT, 2'b01, counter value after reset (weakly not-taken).
- STAT_W, 32, width of the mispredict statistics counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- lk_pc  in  XLEN  PC being fetched (IF)
- lk_hit  out  1  valid BTB entry with matching tag
- lk_taken  out  1  predicted taken
- lk_target  out  XLEN  predicted next PC
- upd_valid  in  1  resolved instruction present this cycle
- upd_pc  in  XLEN  PC of resolved instruction
- upd_is_branch  in  1  conditional branch (B-type)
- upd_is_jump  in  1  jal/jalr
- upd_taken  in  1  branch outcome (ignored for jumps)
- upd_target  in  XLEN  computed target address
- upd_pred_taken  in  1  prediction carried down the pipeline with the instruction
- upd_pred_target  in  XLEN  predicted next PC carried down the pipeline
- mispredict  out  1  flush/redirect request
- redirect_pc  out  XLEN  correct next PC when mispredict=1
- stat_mispred  out  STAT_W  saturating mispredict count

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Reset state: all entry valid bits = 0; all counters = CTR_INIT; stat_mispred = 0. Reset takes priority over a same-cycle update.
- Addressing: idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]. pc[1:0] ignored.
- Lookup (combinational, zero latency, reads the current register state):
  - lk_hit = valid[idx] & (tag[idx] == lk_tag).
  - lk_taken = lk_hit & (jmp[idx] | ctr[idx][1]).
  - lk_target = lk_taken ? tgt[idx] : lk_pc + 4 (mod 2^XLEN).
  - Outputs are combinational on lk_pc and state, so they are valid in the cycle after reset deasserts: miss, not-taken, lk_pc+4.
- Resolution (combinational):
  - actual_taken = upd_is_jump | (upd_is_branch & upd_taken).
  - mispredict = upd_valid & ((upd_pred_taken != actual_taken) | (actual_taken & upd_pred_target != upd_target)).
  - redirect_pc = actual_taken ? upd_target : upd_pc + 4.
  - mispredict = 0 whenever upd_valid = 0.
- Update (on the clk edge when upd_valid=1 and reset=0), at entry idx(upd_pc):
  - Jump: valid=1, tag and tgt written, jmp=1, ctr=2'b11.
  - Branch, entry hit: tgt rewritten, jmp=0; ctr saturating increment if taken, else saturating decrement (3 stays 3, 0 stays 0).
  - Branch, entry miss or invalid: allocate with valid=1, tag, tgt, jmp=0; ctr = upd_taken ? 2'b10 : 2'b01. Replacement is unconditional (direct-mapped).
  - Neither branch nor jump, with a tag hit (alias/stale entry): valid cleared. Tag miss: no change.
  - upd_is_branch and upd_is_jump both 1 is illegal; jump handling wins.
- Same cycle lookup and update on the same idx: lookup returns pre-update contents; the new contents are visible from the next cycle.
- stat_mispred increments by 1 on each clk edge with mispredict=1. It saturates at all-ones and never wraps.
- No internal stall input. The core gates upd_valid for bubbles and flushed instructions.

Decomposition:
- Package bp_pkg:
  - counter constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3;
  - localparam helpers for ENTRIES and TAG_W = XLEN-IDX_W-2.
- Sub-module bp_sat_ctr: the 2-bit saturating next-state function (inputs ctr, taken, alloc, is_jump; output next ctr). It is instantiated once on the update path.
- Entry storage stays inline as register arrays with reset-clearable valid bits.

Test Plan:
- Reset, then lookup pc=0x00000040 → lk_hit=0, lk_taken=0, lk_target=0x00000044, stat_mispred=0.
- Update branch pc=0x40, taken, target=0x80, pred_taken=0 → mispredict=1, redirect_pc=0x80. Next cycle lookup 0x40 → hit, ctr=2, lk_taken=1, lk_target=0x80.
- Four not-taken updates at pc=0x40 after the previous case → counter 2→1→0→0→0 (saturates at 0); lookup → lk_taken=0, lk_target=0x44; redirect_pc=0x44 on each.
- jal at pc=0x100, target=0x20 → ctr=3, jmp=1. Alias pc=0x100+(ENTRIES*4) as a branch → entry replaced and tag changes. Original 0x100 then misses.
- Update and lookup of pc=0x40 in the same cycle → lookup shows old entry; new entry visible the following cycle. Reset asserted together with an update → all entries invalid, stat_mispred=0.
- Force STAT_W=4 and apply 20 mispredicts → stat_mispred stops at 4'hF.
